bpu_update_ctrl: RTL and testbench
==================================

Name: bpu_update_ctrl

Overview:
- Sequences branch-resolution updates into the BPU tables: predictor 0, predictor 1 and the chooser (selector) table.
- The tables share one write port, and fetch-side lookups have priority over it.
- Resolved branches from execute are buffered in a small FIFO. Each one is replayed as up to three table writes.
- The chooser write is skipped when both predictors agree in correctness, matching the "no change" rule of the selector counter.

Parameters:
- DEPTH, 4: update FIFO entries (power of 2, ≥2).
- PC_W, 64: branch PC width.
- IDX_W, 6: table index width.

Ports:
- in_Clk  input  1  clock
- in_Rst  input  1  synchronous reset, active-high
- in_upd_valid  input  1  resolved-branch update offered
- in_upd_pc  input  PC_W  branch PC
- in_upd_taken  input  1  actual outcome
- in_upd_hit  input  2  [1] predictor 1 correct, [0] predictor 0 correct
- out_upd_ready  output  1  FIFO can accept
- in_flush  input  1  discard all queued and in-progress updates
- in_lookup_valid  input  1  fetch owns the table port this cycle
- out_wr_en  output  1  table write strobe
- out_wr_target  output  2  00 predictor 0, 01 predictor 1, 10 chooser
- out_wr_idx  output  IDX_W  table index
- out_wr_data  output  1  counter increment (1) / decrement (0)
- out_busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
Reset:
- FIFO empty, pointers 0, FSM IDLE.
- out_wr_en=0, out_wr_target=00, out_wr_idx=0, out_wr_data=0, out_busy=0.
- out_upd_ready=0 while in_Rst=1; out_upd_ready=1 from the first cycle after reset.

FIFO:
- Push on in_upd_valid & out_upd_ready. Stored fields: {pc[IDX_W+1:2], taken, hit}.
- out_upd_ready = !full & !in_Rst. There is no bypass: when full, a same-cycle pop does not raise ready.
- Pointers are log2(DEPTH) bits and wrap naturally. A count register (log2(DEPTH)+1 bits) distinguishes full from empty.
- Simultaneous push and pop: count unchanged, both pointers advance.

FSM states: IDLE, W_P0, W_P1, W_SEL.
- IDLE: if the FIFO is non-empty, pop the head into the working register (idx, taken, hit) and go to W_P0 next cycle.
- W_P0:
  - Drive target=00, data=taken.
  - out_wr_en = !in_lookup_valid.
  - Advance to W_P1 only in a cycle where out_wr_en=1; otherwise hold.
- W_P1:
  - Same as W_P0, with target=01.
  - On a completed write: if hit==01 or hit==10 go to W_SEL, else go to IDLE.
- W_SEL:
  - target=10, data=hit[1] (1 moves toward predictor 1).
  - Same stall rule; on write go to IDLE.
- out_wr_idx = working idx in every W_* state, 0 in IDLE. out_wr_en=0 in IDLE.

Latency and throughput:
- An update pushed at cycle T is popped at T+1 and first written (W_P0) at T+2 when uncontended.
- Each update takes 3 cycles with a chooser write, 2 without, plus 1 IDLE cycle, plus 1 cycle per lookup stall.
- Stalls are unbounded while in_lookup_valid stays high. All outputs hold stable during a stall.

Flush (and reset mid-operation):
- Clears the FIFO and returns the FSM to IDLE next cycle.
- Any write that would occur in the flush cycle is suppressed: out_wr_en=0 when in_flush=1.
- A push in the flush cycle is dropped.
- in_Rst has priority over in_flush. Both abort identically; reset also forces the reset output values.

out_busy:
- Combinational: (count!=0) | (state!=IDLE).

Test Plan:
- Single update pc=0x1000, taken=1, hit=10, lookups idle → writes at T+2/T+3/T+4: (00, idx=0x00, data=1), (01, 0x00, 1), (10, 0x00, 1). out_busy drops at T+5.
- Update pc=0x1004, hit=11, taken=0 → only two writes, target 00 then 01, idx=0x01, data=0. No chooser write.
- Same as the first test with in_lookup_valid high for 3 cycles during W_P1 → out_wr_en=0 for those cycles, outputs held, then W_P1 and W_SEL complete in order. No write is lost or duplicated.
- Push 4 updates back-to-back with lookups held high → out_upd_ready=0 after the 4th; a 5th offered update is not accepted. Release lookups → all 4 drain in FIFO order with correct idx/data, and ready returns after the first pop.
- Flush while in W_P0 with 2 entries queued → no write in the flush cycle, IDLE next cycle, out_busy=0, no further writes.
- Assert in_Rst mid-W_SEL → next cycle all outputs at reset values, FIFO empty. A new update afterwards behaves as in the first test.

Source files
------------

// File: rtl/bpu_update_ctrl.sv
// Branch-resolution update sequencer: buffers resolved branches in a FIFO and
// replays each one as predictor 0 / predictor 1 / chooser writes on the shared table port.
module bpu_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64,
  parameter int IDX_W = 6
) (
  input  logic             in_Clk,
  input  logic             in_Rst,
  input  logic             in_upd_valid,
  input  logic [PC_W-1:0]  in_upd_pc,
  input  logic             in_upd_taken,
  input  logic [1:0]       in_upd_hit,
  output logic             out_upd_ready,
  input  logic             in_flush,
  input  logic             in_lookup_valid,
  output logic             out_wr_en,
  output logic [1:0]       out_wr_target,
  output logic [IDX_W-1:0] out_wr_idx,
  output logic             out_wr_data,
  output logic             out_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = IDX_W + 3;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, W_P0, W_P1, W_SEL} state_e;

  state_e           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic [IDX_W-1:0] idx_q;
  logic             taken_q;
  logic [1:0]       hit_q;

  logic full, empty, abort, push, pop, wr_en;
  logic [EW-1:0] head;

  logic unused_pc;
  assign unused_pc = ^{in_upd_pc[PC_W-1:IDX_W+2], in_upd_pc[1:0]};

  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign abort         = in_Rst | in_flush;
  assign out_upd_ready = !full & !in_Rst;
  assign push          = in_upd_valid & out_upd_ready & !in_flush;
  assign pop           = (state_q == IDLE) & !empty & !abort;
  assign head          = mem_q[rptr_q];
  assign out_busy      = !empty | (state_q != IDLE);

  // FIFO storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge in_Clk) begin
    if (push) mem_q[wptr_q] <= {in_upd_pc[IDX_W+1:2], in_upd_taken, in_upd_hit};
  end

  always_ff @(posedge in_Clk) begin
    if (abort) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      idx_q   <= '0;
      taken_q <= 1'b0;
      hit_q   <= '0;
    end else if (pop) begin
      {idx_q, taken_q, hit_q} <= head;
    end
  end

  always_ff @(posedge in_Clk) begin
    if (in_Rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (in_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!empty) state_d = W_P0;
        W_P0:    if (wr_en) state_d = W_P1;
        W_P1:    if (wr_en) state_d = (hit_q == 2'b01 || hit_q == 2'b10) ? W_SEL : IDLE;
        W_SEL:   if (wr_en) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en         = (state_q != IDLE) & !in_lookup_valid & !abort;
    out_wr_target = 2'b00;
    out_wr_data   = 1'b0;
    out_wr_idx    = '0;
    case (state_q)
      W_P0: begin
        out_wr_target = 2'b00;
        out_wr_data   = taken_q;
        out_wr_idx    = idx_q;
      end
      W_P1: begin
        out_wr_target = 2'b01;
        out_wr_data   = taken_q;
        out_wr_idx    = idx_q;
      end
      W_SEL: begin
        out_wr_target = 2'b10;
        out_wr_data   = hit_q[1];
        out_wr_idx    = idx_q;
      end
      default: ;
    endcase
  end

  assign out_wr_en = wr_en;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Directed bench for bpu_update_ctrl: write sequencing, stalls, FIFO full, flush and reset.
module tb_bpu_update_ctrl;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [1:0]  upd_hit;
  logic        upd_ready;
  logic        flush;
  logic        lookup;
  logic        wr_en;
  logic [1:0]  wr_target;
  logic [5:0]  wr_idx;
  logic        wr_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  bpu_update_ctrl #(.DEPTH(4), .PC_W(64), .IDX_W(6)) dut (
    .in_Clk          (clk),
    .in_Rst          (rst),
    .in_upd_valid    (upd_valid),
    .in_upd_pc       (upd_pc),
    .in_upd_taken    (upd_taken),
    .in_upd_hit      (upd_hit),
    .out_upd_ready   (upd_ready),
    .in_flush        (flush),
    .in_lookup_valid (lookup),
    .out_wr_en       (wr_en),
    .out_wr_target   (wr_target),
    .out_wr_idx      (wr_idx),
    .out_wr_data     (wr_data),
    .out_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 3ns after the edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
  endtask

  // Expected write-port vector {en, target, idx, data}.
  task automatic expect_wr(input string tag, input logic en, input logic [1:0] tgt,
                           input logic [5:0] idx, input logic data);
    check(tag, {54'd0, wr_en, wr_target, wr_idx, wr_data}, {54'd0, en, tgt, idx, data});
  endtask

  task automatic offer(input logic [63:0] pc, input logic taken, input logic [1:0] hit);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = taken;
    upd_hit   = hit;
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0;
    flush     = 1'b0;
    lookup    = 1'b0;
  endtask

  task automatic basic_update(input string tag);
    next(); offer(64'h1000, 1'b1, 2'b10); sample();
    check({tag, "_ready"}, upd_ready, 1);
    next(); upd_valid = 1'b0; sample();
    expect_wr({tag, "_t1"}, 0, 2'b00, 6'h00, 0);
    check({tag, "_busy_t1"}, busy, 1);
    next(); sample(); expect_wr({tag, "_p0"},  1, 2'b00, 6'h00, 1);
    next(); sample(); expect_wr({tag, "_p1"},  1, 2'b01, 6'h00, 1);
    next(); sample(); expect_wr({tag, "_sel"}, 1, 2'b10, 6'h00, 1);
    next(); sample(); expect_wr({tag, "_done"}, 0, 2'b00, 6'h00, 0);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; upd_pc = '0; upd_taken = 1'b0; upd_hit = '0;
    idle_inputs();

    // Reset state
    next(); next(); sample();
    check("rst_ready", upd_ready, 0);
    expect_wr("rst_wr", 0, 2'b00, 6'h00, 0);
    check("rst_busy", busy, 0);
    next(); rst = 1'b0; sample();
    check("post_rst_ready", upd_ready, 1);

    // Single update with chooser write
    basic_update("t1");

    // Both predictors correct: no chooser write
    next(); offer(64'h1004, 1'b0, 2'b11);
    next(); upd_valid = 1'b0;
    next(); sample(); expect_wr("t2_p0", 1, 2'b00, 6'h01, 0);
    next(); sample(); expect_wr("t2_p1", 1, 2'b01, 6'h01, 0);
    next(); sample(); expect_wr("t2_done", 0, 2'b00, 6'h00, 0);
    check("t2_busy", busy, 0);

    // Lookup stall during W_P1
    next(); offer(64'h1000, 1'b1, 2'b10);
    next(); upd_valid = 1'b0;
    next(); sample(); expect_wr("t3_p0", 1, 2'b00, 6'h00, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      next(); lookup = 1'b1; sample();
      expect_wr("t3_stall", 0, 2'b01, 6'h00, 1);
    end
    next(); lookup = 1'b0; sample(); expect_wr("t3_p1", 1, 2'b01, 6'h00, 1);
    next(); sample(); expect_wr("t3_sel", 1, 2'b10, 6'h00, 1);
    next(); sample(); expect_wr("t3_done", 0, 2'b00, 6'h00, 0);
    check("t3_busy", busy, 0);

    // FIFO full: one update parked in W_P0 by lookups, then four more fill the FIFO
    next(); lookup = 1'b1; offer(64'h3000, 1'b0, 2'b00);
    next(); offer(64'h3004, 1'b1, 2'b01);
    next(); offer(64'h3008, 1'b0, 2'b10);
    next(); offer(64'h300C, 1'b1, 2'b11);
    next(); offer(64'h30F0, 1'b0, 2'b00);
    next(); offer(64'h3010, 1'b1, 2'b10); sample();
    check("t4_full_ready", upd_ready, 0);
    expect_wr("t4_stalled", 0, 2'b00, 6'h00, 0);
    next(); upd_valid = 1'b0; lookup = 1'b0; sample();
    check("t4_still_full", upd_ready, 0);
    expect_wr("t4_a_p0", 1, 2'b00, 6'h00, 0);
    next(); sample(); expect_wr("t4_a_p1", 1, 2'b01, 6'h00, 0);
    next(); sample(); expect_wr("t4_idle0", 0, 2'b00, 6'h00, 0);
    check("t4_ready_at_pop", upd_ready, 0);
    next(); sample(); expect_wr("t4_b1_p0", 1, 2'b00, 6'h01, 1);
    check("t4_ready_after_pop", upd_ready, 1);
    next(); sample(); expect_wr("t4_b1_p1",  1, 2'b01, 6'h01, 1);
    next(); sample(); expect_wr("t4_b1_sel", 1, 2'b10, 6'h01, 0);
    next(); sample(); expect_wr("t4_idle1",  0, 2'b00, 6'h00, 0);
    next(); sample(); expect_wr("t4_b2_p0",  1, 2'b00, 6'h02, 0);
    next(); sample(); expect_wr("t4_b2_p1",  1, 2'b01, 6'h02, 0);
    next(); sample(); expect_wr("t4_b2_sel", 1, 2'b10, 6'h02, 1);
    next(); sample(); expect_wr("t4_idle2",  0, 2'b00, 6'h00, 0);
    next(); sample(); expect_wr("t4_b3_p0",  1, 2'b00, 6'h03, 1);
    next(); sample(); expect_wr("t4_b3_p1",  1, 2'b01, 6'h03, 1);
    next(); sample(); expect_wr("t4_idle3",  0, 2'b00, 6'h00, 0);
    next(); sample(); expect_wr("t4_b4_p0",  1, 2'b00, 6'h3C, 0);
    next(); sample(); expect_wr("t4_b4_p1",  1, 2'b01, 6'h3C, 0);
    next(); sample(); expect_wr("t4_drained", 0, 2'b00, 6'h00, 0);
    check("t4_busy", busy, 0);

    // Flush in W_P0 with two entries queued; a push in the flush cycle is dropped
    next(); lookup = 1'b1; offer(64'h4000, 1'b1, 2'b01);
    next(); offer(64'h4004, 1'b1, 2'b01);
    next(); offer(64'h4008, 1'b1, 2'b01);
    next(); flush = 1'b1; lookup = 1'b0; offer(64'h400C, 1'b1, 2'b01); sample();
    expect_wr("t5_flush_cycle", 0, 2'b00, 6'h00, 1);
    next(); idle_inputs(); sample();
    expect_wr("t5_after", 0, 2'b00, 6'h00, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", upd_ready, 1);
    next(); sample();
    expect_wr("t5_quiet", 0, 2'b00, 6'h00, 0);

    // Reset during W_SEL
    next(); offer(64'h1000, 1'b1, 2'b10);
    next(); upd_valid = 1'b0;
    next(); next(); next(); rst = 1'b1; sample();
    expect_wr("t6_rst_cycle", 0, 2'b10, 6'h00, 1);
    check("t6_rst_ready", upd_ready, 0);
    next(); rst = 1'b0; sample();
    expect_wr("t6_after", 0, 2'b00, 6'h00, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", upd_ready, 1);
    basic_update("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
